// File: rtl/ball_motion.sv
// Pong ball engine. It holds the ball position and direction, advances both on
// a prescaled tick, bounces off the walls and the paddles, and flags goals.
module ball_motion #(
  parameter int MAX_X      = 640,
  parameter int MAX_Y      = 480,
  parameter int BALL_SIZE  = 8,
  parameter int BALL_V     = 2,
  parameter int SERVE_WAIT = 60
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [21:0] prescaler,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [9:0]  L_BAR_X_L,
  input  logic [9:0]  L_BAR_X_R,
  input  logic [9:0]  L_BAR_Y_T,
  input  logic [9:0]  L_BAR_Y_B,
  input  logic [9:0]  R_BAR_X_L,
  input  logic [9:0]  R_BAR_X_R,
  input  logic [9:0]  R_BAR_Y_T,
  input  logic [9:0]  R_BAR_Y_B,
  input  logic        serve_button,
  output logic        ball_on,
  output logic [7:0]  ball_rgb,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic        score_left,
  output logic        score_right
);

  // Geometry is evaluated in 11 bits so that sums near the screen edge
  // cannot wrap before they are compared.
  localparam logic [9:0]  CENTRE_X   = 10'(MAX_X / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  CENTRE_Y   = 10'(MAX_Y / 2 - BALL_SIZE / 2);
  localparam logic [10:0] STEP       = 11'(BALL_V);
  localparam logic [10:0] SIZE       = 11'(BALL_SIZE);
  localparam logic [10:0] Y_LIMIT    = 11'(MAX_Y - BALL_SIZE);
  localparam logic [10:0] X_LIMIT    = 11'(MAX_X - BALL_SIZE);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_WAIT - 1);

  typedef enum logic [1:0] {
    S_SERVE,
    S_PLAY,
    S_SCORED
  } state_t;

  // One vertical step: clamps to the wall and reverses when the step would
  // reach or cross it. Result is {new_dir, new_pos}.
  function automatic logic [10:0] bounce_y(input logic [10:0] pos, input logic dir);
    logic [10:0] sum;
    sum = pos + STEP;
    if (dir) begin
      if (sum >= Y_LIMIT) bounce_y = {1'b0, Y_LIMIT[9:0]};
      else                bounce_y = {1'b1, sum[9:0]};
    end else begin
      if (pos <= STEP)    bounce_y = {1'b1, 10'd0};
      else                bounce_y = {1'b0, 10'(pos - STEP)};
    end
  endfunction

  state_t      state, state_n;
  logic [21:0] tick_cnt;
  logic        tick;
  logic [7:0]  serve_cnt, serve_cnt_n;
  logic        dir_x, dir_x_n;
  logic        dir_y, dir_y_n;
  logic [9:0]  ball_x_n, ball_y_n;
  logic        score_left_n, score_right_n;

  // Candidate PLAY-step results, valid whenever state is PLAY.
  logic [9:0]  play_x, play_y;
  logic        play_dx, play_dy;
  logic        goal_l, goal_r;

  logic [10:0] bx, by, r_edge, y_res;
  logic [10:0] lxr, rxl;
  logic        l_ovl, r_ovl, l_hit, r_hit;

  // The outer paddle edges play no part in collision; only the faces do.
  logic        unused_bounds;
  assign unused_bounds = ^{L_BAR_X_L, R_BAR_X_R};

  assign tick     = (tick_cnt == prescaler);
  assign ball_rgb = 8'b111_111_11;

  assign bx     = {1'b0, ball_x};
  assign by     = {1'b0, ball_y};
  assign r_edge = bx + SIZE - 11'd1;
  assign lxr    = {1'b0, L_BAR_X_R};
  assign rxl    = {1'b0, R_BAR_X_L};

  assign l_ovl = (by + SIZE - 11'd1 >= {1'b0, L_BAR_Y_T}) && (by <= {1'b0, L_BAR_Y_B});
  assign r_ovl = (by + SIZE - 11'd1 >= {1'b0, R_BAR_Y_T}) && (by <= {1'b0, R_BAR_Y_B});

  // Only a ball still in front of the paddle face can hit it, so a missed
  // paddle is never struck from behind.
  assign l_hit = (bx > lxr) && (bx <= lxr + STEP) && l_ovl;
  assign r_hit = (r_edge < rxl) && (r_edge + STEP >= rxl) && r_ovl;

  // Scan pixel inside the ball square, independent of game state.
  assign ball_on = ({1'b0, x} >= bx) && ({1'b0, x} <= bx + SIZE - 11'd1) &&
                   ({1'b0, y} >= by) && ({1'b0, y} <= by + SIZE - 11'd1);

  // Tick prescaler: wraps through 2^22 if prescaler drops below the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 22'd1;
  end

  // One PLAY step: both axes from the current registers, paddle before goal.
  always_comb begin
    play_x  = ball_x;
    play_dx = dir_x;
    goal_l  = 1'b0;
    goal_r  = 1'b0;
    y_res   = bounce_y(by, dir_y);
    play_y  = y_res[9:0];
    play_dy = y_res[10];
    if (!dir_x) begin
      if (l_hit) begin
        play_x  = 10'(lxr + 11'd1);
        play_dx = 1'b1;
      end else if (bx <= STEP) begin
        goal_r = 1'b1;
      end else begin
        play_x = 10'(bx - STEP);
      end
    end else begin
      if (r_hit) begin
        play_x  = 10'(rxl - SIZE);
        play_dx = 1'b0;
      end else if (bx + STEP >= X_LIMIT) begin
        goal_l = 1'b1;
      end else begin
        play_x = 10'(bx + STEP);
      end
    end
  end

  // State and ball registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_SERVE;
      ball_x      <= CENTRE_X;
      ball_y      <= CENTRE_Y;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      serve_cnt   <= '0;
      score_left  <= 1'b0;
      score_right <= 1'b0;
    end else begin
      state       <= state_n;
      ball_x      <= ball_x_n;
      ball_y      <= ball_y_n;
      dir_x       <= dir_x_n;
      dir_y       <= dir_y_n;
      serve_cnt   <= serve_cnt_n;
      score_left  <= score_left_n;
      score_right <= score_right_n;
    end
  end

  // Next state: serve hold, tick-gated play, and the single-cycle goal state.
  always_comb begin
    state_n       = state;
    ball_x_n      = ball_x;
    ball_y_n      = ball_y;
    dir_x_n       = dir_x;
    dir_y_n       = dir_y;
    serve_cnt_n   = serve_cnt;
    score_left_n  = 1'b0;
    score_right_n = 1'b0;
    unique case (state)
      S_SERVE: begin
        ball_x_n = CENTRE_X;
        ball_y_n = CENTRE_Y;
        if (tick) begin
          serve_cnt_n = serve_cnt + 8'd1;
          if (!serve_button || serve_cnt == SERVE_LAST) state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (goal_l) begin
            state_n      = S_SCORED;
            score_left_n = 1'b1;
          end else if (goal_r) begin
            state_n       = S_SCORED;
            score_right_n = 1'b1;
          end else begin
            ball_x_n = play_x;
            ball_y_n = play_y;
            dir_x_n  = play_dx;
            dir_y_n  = play_dy;
          end
        end
      end
      S_SCORED: begin
        // Directions are kept so the next serve heads toward the conceder.
        state_n     = S_SERVE;
        ball_x_n    = CENTRE_X;
        ball_y_n    = CENTRE_Y;
        serve_cnt_n = '0;
      end
      default: begin
        state_n = S_SERVE;
      end
    endcase
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: stimulus queues cycle-stamped expectations,
// a monitor pops and compares them, and a second monitor accounts every pulse.
module tb_ball_motion;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [21:0] prescaler;
  logic [9:0]  x, y;
  logic [9:0]  L_BAR_X_L, L_BAR_X_R, L_BAR_Y_T, L_BAR_Y_B;
  logic [9:0]  R_BAR_X_L, R_BAR_X_R, R_BAR_Y_T, R_BAR_Y_B;
  logic        serve_button;
  logic        ball_on;
  logic [7:0]  ball_rgb;
  logic [9:0]  ball_x, ball_y;
  logic        score_left, score_right;

  ball_motion dut (
    .CLK(CLK), .RST_N(RST_N), .prescaler(prescaler), .x(x), .y(y),
    .L_BAR_X_L(L_BAR_X_L), .L_BAR_X_R(L_BAR_X_R), .L_BAR_Y_T(L_BAR_Y_T), .L_BAR_Y_B(L_BAR_Y_B),
    .R_BAR_X_L(R_BAR_X_L), .R_BAR_X_R(R_BAR_X_R), .R_BAR_Y_T(R_BAR_Y_T), .R_BAR_Y_B(R_BAR_Y_B),
    .serve_button(serve_button), .ball_on(ball_on), .ball_rgb(ball_rgb),
    .ball_x(ball_x), .ball_y(ball_y), .score_left(score_left), .score_right(score_right)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int bx;
    int by;
    bit on;
    bit sl;
    bit sr;
  } exp_t;

  typedef struct {
    int cyc;
    bit left;
  } pulse_t;

  exp_t   exp_q[$];
  pulse_t pulse_q[$];
  int     checks = 0;
  int     fails  = 0;
  int     cyc;

  // Clock edges since the last reset release.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic expect_at(input int c, input int bx, input int by,
                           input bit on, input bit sl, input bit sr);
    exp_t e;
    e.cyc = c; e.bx = bx; e.by = by; e.on = on; e.sl = sl; e.sr = sr;
    exp_q.push_back(e);
  endtask

  task automatic expect_pulse(input int c, input bit left);
    pulse_t p;
    p.cyc = c; p.left = left;
    pulse_q.push_back(p);
  endtask

  // Position/output monitor.
  always @(negedge CLK) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; fails++;
      $display("FAIL missed@cyc%0d: monitor reached cyc %0d first", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      checks++;
      if (ball_x !== 10'(exp_q[0].bx) || ball_y !== 10'(exp_q[0].by) ||
          ball_on !== exp_q[0].on || score_left !== exp_q[0].sl ||
          score_right !== exp_q[0].sr || ball_rgb !== 8'hFF) begin
        fails++;
        $display("FAIL state@cyc%0d: got x=%0d y=%0d on=%0b sl=%0b sr=%0b rgb=%h, need x=%0d y=%0d on=%0b sl=%0b sr=%0b rgb=ff",
                 cyc, ball_x, ball_y, ball_on, score_left, score_right, ball_rgb,
                 exp_q[0].bx, exp_q[0].by, exp_q[0].on, exp_q[0].sl, exp_q[0].sr);
      end
      void'(exp_q.pop_front());
    end
  end

  // Pulse monitor: every cycle with a score pulse must match a queued pulse.
  always @(negedge CLK) begin
    if (score_left === 1'b1 || score_right === 1'b1) begin
      checks++;
      if (pulse_q.size() == 0) begin
        fails++;
        $display("FAIL pulse@cyc%0d: got sl=%0b sr=%0b, need no pulse", cyc, score_left, score_right);
      end else begin
        if (pulse_q[0].cyc != cyc || score_left !== pulse_q[0].left ||
            score_right !== !pulse_q[0].left) begin
          fails++;
          $display("FAIL pulse@cyc%0d: got sl=%0b sr=%0b, need cyc=%0d left=%0b",
                   cyc, score_left, score_right, pulse_q[0].cyc, pulse_q[0].left);
        end
        void'(pulse_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: got %0d entries left, need 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "timeout");
  end

  int on_tab[7][3] = '{
    '{316, 236, 1}, '{323, 243, 1}, '{324, 236, 0}, '{315, 236, 0},
    '{316, 244, 0}, '{316, 235, 0}, '{320, 240, 1}
  };

  initial begin
    // Rally: serve right, bottom wall, right paddle, top wall, left paddle,
    // right paddle again, then the left paddle is moved away and the ball scores.
    RST_N = 1'b1;
    prescaler = 22'd0; serve_button = 1'b0; x = '0; y = '0;
    L_BAR_X_L = 10'd20;  L_BAR_X_R = 10'd23;  L_BAR_Y_T = 10'd0; L_BAR_Y_B = 10'd479;
    R_BAR_X_L = 10'd620; R_BAR_X_R = 10'd623; R_BAR_Y_T = 10'd0; R_BAR_Y_B = 10'd479;
    #2 RST_N = 1'b0;
    expect_at(0,    316, 236, 0, 0, 0);
    expect_at(1,    316, 236, 0, 0, 0);
    expect_at(2,    318, 238, 0, 0, 0);
    expect_at(118,  550, 470, 0, 0, 0);
    expect_at(119,  552, 472, 0, 0, 0);
    expect_at(120,  554, 470, 0, 0, 0);
    expect_at(148,  610, 414, 0, 0, 0);
    expect_at(149,  612, 412, 0, 0, 0);
    expect_at(150,  612, 410, 0, 0, 0);
    expect_at(151,  610, 408, 0, 0, 0);
    expect_at(354,  204,   2, 0, 0, 0);
    expect_at(355,  202,   0, 0, 0, 0);
    expect_at(356,  200,   2, 0, 0, 0);
    expect_at(443,   26, 176, 0, 0, 0);
    expect_at(444,   24, 178, 0, 0, 0);
    expect_at(445,   24, 180, 0, 0, 0);
    expect_at(446,   26, 182, 0, 0, 0);
    expect_at(739,  612, 176, 0, 0, 0);
    expect_at(740,  612, 174, 0, 0, 0);
    expect_at(741,  610, 172, 0, 0, 0);
    expect_at(1045,   2, 436, 0, 0, 0);
    expect_at(1046,   2, 436, 0, 0, 1);
    expect_at(1047, 316, 236, 0, 0, 0);
    expect_at(1048, 316, 236, 0, 0, 0);
    expect_at(1049, 314, 238, 0, 0, 0);
    expect_pulse(1046, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    wait_cyc(600);
    L_BAR_Y_B = 10'd71;
    wait_cyc(1052);
    drain("rally");

    // Auto-serve after the wait with a slow tick, then reset during play.
    @(posedge CLK);
    #1 RST_N = 1'b0;
    prescaler = 22'd3; serve_button = 1'b1;
    expect_at(0, 316, 236, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    wait_cyc(10);
    for (int i = 0; i < 7; i++) begin
      x = 10'(on_tab[i][0]);
      y = 10'(on_tab[i][1]);
      expect_at(cyc, 316, 236, on_tab[i][2] != 0, 0, 0);
      @(posedge CLK);
      #1;
    end
    x = '0; y = '0;
    expect_at(239, 316, 236, 0, 0, 0);
    expect_at(243, 316, 236, 0, 0, 0);
    expect_at(244, 318, 238, 0, 0, 0);
    expect_at(300, 346, 266, 0, 0, 0);
    wait_cyc(301);
    expect_at(0, 316, 236, 0, 0, 0);
    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    drain("serve");

    checks++;
    if (pulse_q.size() != 0) begin
      fails++;
      $display("FAIL pulses_seen: got %0d expected pulses unseen, need 0", pulse_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
